cordic_host_if: RTL and testbench

- Host-side front end that sits directly upstream of, and wraps the pin interface of, the CORDIC core top-level (Data_in/Enable/IN_N_OUT in, Data_out/Data_Ready out).
- Accepts one I/Q sample per valid/ready handshake and sequences it into the core as two 13-bit words.
- Waits for the core to finish, reads back amplitude (AM) then phase (PM), and presents them together on a valid/ready result port.
- Adds a watchdog so a core that never signals ready cannot hang the host.

---
 rtl/cordic_host_pkg.sv | 18 +
 rtl/cordic_host_wdog.sv | 39 +++
 rtl/cordic_host_if.sv | 162 ++++++++++++++++
 tb/tb_cordic_host_if.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_host_pkg.sv
// Shared definitions for the CORDIC host front end: FSM state encoding and
// default widths/limits used by the top and the watchdog.
package cordic_host_pkg;

    localparam int DW_DEF      = 13;
    localparam int TIMEOUT_DEF = 64;
    localparam int CW_DEF      = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_Q   = 3'd1,
        WAIT_RDY = 3'd2,
        READ_AM  = 3'd3,
        READ_PM  = 3'd4,
        HOLD     = 3'd5
    } state_e;

endpackage

// File: rtl/cordic_host_wdog.sv
// Watchdog for the wait-for-ready phase: a clearable up-counter whose
// terminal-count flag marks the last cycle the host is willing to wait.
module cordic_host_wdog
    import cordic_host_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

    // Saturate at terminal count so a stuck core can never wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_host_if.sv
// Host-side front end for the CORDIC core: takes one I/Q sample per handshake,
// writes it to the core as two words, reads back AM/PM and presents the pair.
module cordic_host_if
    import cordic_host_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_i,
    input  logic [DW-1:0] s_q,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_am,
    output logic [DW-1:0] m_pm,
    output logic          timeout_err,
    output logic [DW-1:0] core_data_in,
    output logic          core_enable,
    output logic          core_in_n_out,
    input  logic [DW-1:0] core_data_out,
    input  logic          core_data_ready
);

    state_e        state_q, state_d;
    logic [DW-1:0] q_hold_q, q_hold_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_am_q, m_am_d;
    logic [DW-1:0] m_pm_q, m_pm_d;
    logic          timeout_err_q, timeout_err_d;
    logic [DW-1:0] core_data_in_q, core_data_in_d;
    logic          core_enable_q, core_enable_d;
    logic          core_in_n_out_q, core_in_n_out_d;
    logic          wd_clr;
    logic          wd_inc;
    logic          wd_tc;

    cordic_host_wdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_wdog (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .tc    (wd_tc)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without this the tool infers latches.
    always_comb begin
        state_d         = state_q;
        q_hold_d        = q_hold_q;
        s_ready_d       = 1'b0;
        m_valid_d       = m_valid_q;
        m_am_d          = m_am_q;
        m_pm_d          = m_pm_q;
        timeout_err_d   = timeout_err_q;
        core_data_in_d  = core_data_in_q;
        core_enable_d   = 1'b0;
        core_in_n_out_d = core_in_n_out_q;
        wd_clr          = 1'b0;
        wd_inc          = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    q_hold_d        = s_q;
                    core_data_in_d  = s_i;
                    core_enable_d   = 1'b1;
                    core_in_n_out_d = 1'b1;
                    state_d         = LOAD_Q;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            LOAD_Q: begin
                core_data_in_d  = q_hold_q;
                core_enable_d   = 1'b1;
                core_in_n_out_d = 1'b1;
                wd_clr          = 1'b1;
                state_d         = WAIT_RDY;
            end
            WAIT_RDY: begin
                wd_inc = 1'b1;
                // A ready core wins over a watchdog expiring in the same cycle.
                if (core_data_ready) begin
                    core_enable_d   = 1'b1;
                    core_in_n_out_d = 1'b0;
                    state_d         = READ_AM;
                end else if (wd_tc) begin
                    timeout_err_d = 1'b1;
                    s_ready_d     = 1'b1;
                    state_d       = IDLE;
                end
            end
            READ_AM: begin
                m_am_d          = core_data_out;
                core_enable_d   = 1'b1;
                core_in_n_out_d = 1'b0;
                state_d         = READ_PM;
            end
            READ_PM: begin
                m_pm_d    = core_data_out;
                m_valid_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q         <= IDLE;
            q_hold_q        <= '0;
            s_ready_q       <= 1'b0;
            m_valid_q       <= 1'b0;
            m_am_q          <= '0;
            m_pm_q          <= '0;
            timeout_err_q   <= 1'b0;
            core_data_in_q  <= '0;
            core_enable_q   <= 1'b0;
            core_in_n_out_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            q_hold_q        <= q_hold_d;
            s_ready_q       <= s_ready_d;
            m_valid_q       <= m_valid_d;
            m_am_q          <= m_am_d;
            m_pm_q          <= m_pm_d;
            timeout_err_q   <= timeout_err_d;
            core_data_in_q  <= core_data_in_d;
            core_enable_q   <= core_enable_d;
            core_in_n_out_q <= core_in_n_out_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign m_valid       = m_valid_q;
    assign m_am          = m_am_q;
    assign m_pm          = m_pm_q;
    assign timeout_err   = timeout_err_q;
    assign core_data_in  = core_data_in_q;
    assign core_enable   = core_enable_q;
    assign core_in_n_out = core_in_n_out_q;

endmodule

// File: tb/tb_cordic_host_if.sv
// Bench for cordic_host_if: a behavioural CORDIC core pin model, a timeline
// model of the expected host behaviour, and a per-cycle compare process.
module tb_cordic_host_if;

    localparam int DW = 13;
    localparam int TO = 16;

    logic          CLK;
    logic          RESET;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_i;
    logic [DW-1:0] s_q;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_am;
    logic [DW-1:0] m_pm;
    logic          timeout_err;
    logic [DW-1:0] core_data_in;
    logic          core_enable;
    logic          core_in_n_out;
    logic [DW-1:0] core_data_out;
    logic          core_data_ready;

    cordic_host_if #(.DW(DW), .TIMEOUT(TO), .CW(10)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_i             (s_i),
        .s_q             (s_q),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_am            (m_am),
        .m_pm            (m_pm),
        .timeout_err     (timeout_err),
        .core_data_in    (core_data_in),
        .core_enable     (core_enable),
        .core_in_n_out   (core_in_n_out),
        .core_data_out   (core_data_out),
        .core_data_ready (core_data_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-sample plan: how long the core model takes and what it returns.
    typedef struct {
        int            n;
        bit            never;
        bit            glitch;
        logic [DW-1:0] am;
        logic [DW-1:0] pm;
    } plan_t;

    plan_t plan_q[$];

    int            d_n;
    bit            d_never;
    bit            d_glitch;
    logic [DW-1:0] d_am;
    logic [DW-1:0] d_pm;

    function automatic plan_t mk_plan(input int n, input bit nev, input bit gl,
                                      input logic [DW-1:0] am, input logic [DW-1:0] pm);
        plan_t p;
        p.n = n; p.never = nev; p.glitch = gl; p.am = am; p.pm = pm;
        return p;
    endfunction

    // ---------------- Core pin model ----------------
    bit            wr_second, rd_second, computing, cur_glitch, rdy;
    int            rem;
    logic [DW-1:0] cur_am, cur_pm;

    assign core_data_ready = rdy;
    assign core_data_out   = rd_second ? cur_pm : cur_am;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_second <= 0; rd_second <= 0; computing <= 0; cur_glitch <= 0;
            rdy <= 0; rem <= 0; cur_am <= '0; cur_pm <= '0;
            plan_q.delete();
        end else begin
            if (core_enable && core_in_n_out) begin
                wr_second <= !wr_second;
                if (wr_second && plan_q.size() > 0) begin
                    cur_am     <= plan_q[0].am;
                    cur_pm     <= plan_q[0].pm;
                    cur_glitch <= plan_q[0].glitch;
                    if (plan_q[0].never) begin
                        computing <= 0;
                    end else if (plan_q[0].n <= 1) begin
                        rdy <= 1;
                    end else begin
                        computing <= 1;
                        rem       <= plan_q[0].n - 1;
                    end
                    void'(plan_q.pop_front());
                end
            end else if (computing) begin
                if (rem == 1) begin
                    rdy       <= 1;
                    computing <= 0;
                end
                rem <= rem - 1;
            end
            if (core_enable && !core_in_n_out) begin
                rd_second <= !rd_second;
                if (rd_second) rdy <= 0;
            end
            if (rdy && !core_enable && cur_glitch) rdy <= 0;
        end
    end

    // ---------------- Host timeline model ----------------
    // k counts cycles since the accept cycle; N is the number of WAIT_RDY
    // cycles during which the core is not ready.
    bit            md_up, md_busy, md_hold, md_never, md_terr;
    int            md_k, md_n;
    logic [DW-1:0] md_i, md_q, md_am, md_pm;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            md_up <= 0; md_busy <= 0; md_hold <= 0; md_terr <= 0; md_k <= 0;
        end else begin
            md_up <= 1;
            if (!md_busy) begin
                if (md_up && s_valid) begin
                    md_busy  <= 1;
                    md_k     <= 1;
                    md_i     <= s_i;
                    md_q     <= s_q;
                    md_n     <= d_n;
                    md_never <= d_never;
                    md_am    <= d_am;
                    md_pm    <= d_pm;
                    plan_q.push_back(mk_plan(d_n, d_never, d_glitch, d_am, d_pm));
                end
            end else if (md_hold) begin
                if (m_ready) begin
                    md_busy <= 0;
                    md_hold <= 0;
                end
            end else begin
                md_k <= md_k + 1;
                if (md_never && md_k + 1 == TO + 2) begin
                    md_busy <= 0;
                    md_terr <= 1;
                end
                if (!md_never && md_k + 1 == md_n + 5) md_hold <= 1;
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge CLK) begin
        bit exp_en;
        exp_en = md_busy && !md_hold &&
                 (md_k == 1 || md_k == 2 || (!md_never && (md_k == md_n + 3 || md_k == md_n + 4)));
        check("s_ready", s_ready, md_up && !md_busy);
        check("m_valid", m_valid, md_hold);
        check("timeout_err", timeout_err, md_terr);
        check("core_enable", core_enable, exp_en);
        if (exp_en) check("core_in_n_out", core_in_n_out, md_k <= 2);
        if (exp_en && md_k == 1) check("core_data_in_i", core_data_in, md_i);
        if (exp_en && md_k == 2) check("core_data_in_q", core_data_in, md_q);
        if (md_hold) begin
            check("m_am", m_am, md_am);
            check("m_pm", m_pm, md_pm);
        end
        if (!RESET) begin
            check("rst_m_am", m_am, 0);
            check("rst_m_pm", m_pm, 0);
            check("rst_core_data_in", core_data_in, 0);
            check("rst_core_in_n_out", core_in_n_out, 0);
        end
    end

    logic [2*DW-1:0] got_q[$];
    always @(negedge CLK) if (m_valid && m_ready) got_q.push_back({m_am, m_pm});

    // ---------------- Stimulus helpers ----------------
    int acc_cyc;

    task automatic send(input logic [DW-1:0] i, input logic [DW-1:0] q, input int n,
                        input bit nev, input bit gl, input logic [DW-1:0] am, input logic [DW-1:0] pm);
        bit ok;
        ok = 0;
        d_n = n; d_never = nev; d_glitch = gl; d_am = am; d_pm = pm;
        s_i = i; s_q = q; s_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (s_ready === 1'b1) begin
                acc_cyc = cyc;
                ok = 1;
                break;
            end
        end
        check("accept_in_time", ok, 1);
        @(posedge CLK);
        #2;
        s_valid = 1'b0;
        s_i = DW'($urandom_range(0, 8191));
        s_q = DW'($urandom_range(0, 8191));
    endtask

    // Runs the in-flight sample to completion; garbage s_valid while busy.
    task automatic run_txn(input bit mr_rand);
        bit done;
        done = 0;
        for (int t = 0; t < 400; t++) begin
            if (!md_busy) begin
                done = 1;
                break;
            end
            if (!md_hold && md_k <= (md_never ? TO : md_n + 4)) begin
                s_valid = 1'($urandom_range(0, 1));
                s_i = DW'($urandom_range(0, 8191));
                s_q = DW'($urandom_range(0, 8191));
            end else begin
                s_valid = 1'b0;
            end
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK);
            #2;
        end
        s_valid = 1'b0;
        check("txn_done_in_time", done, 1);
    endtask

    task automatic wait_mv(output int c);
        bit ok;
        ok = 0;
        c = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (m_valid === 1'b1) begin
                c = cyc;
                ok = 1;
                break;
            end
        end
        check("m_valid_in_time", ok, 1);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int  c;
        bit  seen_mv;
        bit  ok;
        int  n_got;

        RESET = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0; m_ready = 1'b0;
        d_n = 1; d_never = 0; d_glitch = 0; d_am = '0; d_pm = '0;

        // Reset with random inputs toggling
        for (int t = 0; t < 4; t++) begin
            @(posedge CLK);
            #2;
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_i = DW'($urandom_range(0, 8191));
            s_q = DW'($urandom_range(0, 8191));
        end
        @(negedge CLK);
        check("reset_s_ready", s_ready, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_core_enable", core_enable, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_m_am", m_am, 0);
        s_valid = 1'b0;
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("s_ready_after_release", s_ready, 1);
        #1;

        // Single sample, N=14: m_valid 19 cycles after the accept cycle
        m_ready = 1'b1;
        send(13'h0100, 13'h0000, 14, 0, 0, 13'h0100, 13'h0000);
        check("single_wr_i_data", core_data_in, 13'h0100);
        check("single_wr_i_dir", core_in_n_out, 1);
        @(posedge CLK);
        #2;
        check("single_wr_q_data", core_data_in, 13'h0000);
        check("single_wr_q_en", core_enable, 1);
        wait_mv(c);
        check("single_latency", c - acc_cyc, 19);
        check("single_m_am", m_am, 13'h0100);
        check("single_m_pm", m_pm, 13'h0000);
        @(posedge CLK);
        #2;
        run_txn(0);

        // Backpressure: result held stable while m_ready is low
        m_ready = 1'b0;
        send(13'h0ABC, 13'h1234, 5, 0, 0, 13'h0777, 13'h1555);
        m_ready = 1'b0;
        wait_mv(c);
        check("bp_latency", c - acc_cyc, 10);
        for (int j = 0; j < 10; j++) begin
            check("bp_m_valid", m_valid, 1);
            check("bp_m_am", m_am, 13'h0777);
            check("bp_m_pm", m_pm, 13'h1555);
            check("bp_s_ready", s_ready, 0);
            @(negedge CLK);
        end
        #1 m_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_release_m_valid", m_valid, 0);
        check("bp_release_s_ready", s_ready, 1);
        #1;

        // Timeout: core never ready
        send(13'h0123, 13'h0456, 0, 1, 0, 13'h0000, 13'h0000);
        seen_mv = 0;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK);
            if (m_valid === 1'b1) seen_mv = 1;
            if (timeout_err === 1'b1) begin
                c = cyc;
                ok = 1;
                break;
            end
        end
        check("timeout_seen", ok, 1);
        check("timeout_latency", c - acc_cyc, TO + 2);
        check("timeout_no_result", seen_mv, 0);
        check("timeout_s_ready", s_ready, 1);
        @(posedge CLK);
        #2;
        send(13'h0321, 13'h0654, 4, 0, 0, 13'h0A0A, 13'h0505);
        run_txn(0);

        // Ready exactly on the watchdog's last cycle, then ready dropping in READ_AM
        send(13'h0011, 13'h0022, TO - 1, 0, 0, 13'h0033, 13'h0044);
        run_txn(1);
        send(13'h0055, 13'h0066, 3, 0, 1, 13'h0077, 13'h0088);
        run_txn(1);

        // Mid-operation reset, asserted during READ_AM
        m_ready = 1'b1;
        send(13'h0AAA, 13'h0555, 10, 0, 0, 13'h0001, 13'h0002);
        repeat (12) @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("midrst_core_enable", core_enable, 0);
        check("midrst_core_in_n_out", core_in_n_out, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_timeout_err", timeout_err, 0);
        n_got = got_q.size();
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b1;
        repeat (20) @(negedge CLK);
        check("midrst_no_stale_result", got_q.size(), n_got);
        @(posedge CLK);
        #2;

        // Back-to-back with m_ready held high
        got_q.delete();
        send(13'h1FFF, 13'h1000, 4, 0, 0, 13'h0F0F, 13'h1E1E);
        run_txn(0);
        send(13'h0FFF, 13'h0001, 2, 0, 0, 13'h0333, 13'h0444);
        run_txn(0);
        check("b2b_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("b2b_res0", got_q[0], {13'h0F0F, 13'h1E1E});
            check("b2b_res1", got_q[1], {13'h0333, 13'h0444});
        end

        // Randomized samples
        for (int s = 0; s < 40; s++) begin
            send(DW'($urandom_range(0, 8191)), DW'($urandom_range(0, 8191)),
                 int'($urandom_range(1, TO - 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 DW'($urandom_range(0, 8191)), DW'($urandom_range(0, 8191)));
            run_txn(1);
        end

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
